id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage that feeds `ALU32Bit` in the five-stage MIPS datapath. Each cycle it decodes the ID-stage instruction into the 5-bit ALU operation code and operand routing, and registers it with its control bits. It also detects load-use hazards, inserts bubbles and honours branch flushes. All `Ex*` outputs drive the ALU and the EX/MEM register directly.

---
 rtl/id_ex_stage_if.sv | 34 +++
 rtl/id_ex_stage.sv | 208 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bus: ID-side inputs, stall feedback and EX-side outputs
interface id_ex_stage_if;
    logic        InValid;
    logic [31:0] Instruction;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [31:0] PCPlus4;
    logic        Flush;
    logic        StallID;
    logic        ExValid;
    logic [4:0]  ALUControl;
    logic [31:0] ExA;
    logic [31:0] ExB;
    logic [31:0] ExStoreData;
    logic [31:0] ExPCPlus4;
    logic [4:0]  ExDestReg;
    logic        ExRegWrite;
    logic        ExMemRead;
    logic        ExMemWrite;
    logic        ExBranch;
    logic        IllegalOp;

    modport master (
        output InValid, Instruction, RsData, RtData, PCPlus4, Flush,
        input  StallID, ExValid, ALUControl, ExA, ExB, ExStoreData, ExPCPlus4,
               ExDestReg, ExRegWrite, ExMemRead, ExMemWrite, ExBranch, IllegalOp
    );

    modport slave (
        input  InValid, Instruction, RsData, RtData, PCPlus4, Flush,
        output StallID, ExValid, ALUControl, ExA, ExB, ExStoreData, ExPCPlus4,
               ExDestReg, ExRegWrite, ExMemRead, ExMemWrite, ExBranch, IllegalOp
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - MIPS ID/EX register with ALU decode, load-use stall and flush; mul gated by ID_EX_MUL_EN
module id_ex_stage (
    input  logic           Clk,
    input  logic           Reset,
    id_ex_stage_if.slave   bus
);
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
`ifdef ID_EX_MUL_EN
    localparam logic [4:0] ALU_MUL  = 5'b00011;
`endif
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_AND  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00111;
    localparam logic [4:0] ALU_XOR  = 5'b01000;
    localparam logic [4:0] ALU_BGEZ = 5'b01011;
    localparam logic [4:0] ALU_BEQ  = 5'b01100;
    localparam logic [4:0] ALU_NOR  = 5'b01101;
    localparam logic [4:0] ALU_SLT  = 5'b01110;
    localparam logic [4:0] ALU_BNE  = 5'b01111;
    localparam logic [4:0] ALU_BGTZ = 5'b10000;
    localparam logic [4:0] ALU_BLEZ = 5'b10001;
    localparam logic [4:0] ALU_BLTZ = 5'b10010;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext, imm_zext;

    assign op       = bus.Instruction[31:26];
    assign rs       = bus.Instruction[25:21];
    assign rt       = bus.Instruction[20:16];
    assign rd       = bus.Instruction[15:11];
    assign shamt    = bus.Instruction[10:6];
    assign funct    = bus.Instruction[5:0];
    assign imm_sext = {{16{bus.Instruction[15]}}, bus.Instruction[15:0]};
    assign imm_zext = {16'b0, bus.Instruction[15:0]};

    logic        dec_legal, dec_rw, dec_mr, dec_mw, dec_br, dec_reads_rs, dec_reads_rt;
    logic [4:0]  dec_alu, dec_dest;
    logic [31:0] dec_a, dec_b;

    always_comb begin
        dec_legal    = 1'b0;
        dec_alu      = ALU_NONE;
        dec_a        = bus.RsData;
        dec_b        = bus.RtData;
        dec_dest     = rd;
        dec_rw       = 1'b0;
        dec_mr       = 1'b0;
        dec_mw       = 1'b0;
        dec_br       = 1'b0;
        dec_reads_rs = 1'b1;
        dec_reads_rt = 1'b0;
        case (op)
            6'h00: begin
                dec_rw       = 1'b1;
                dec_reads_rt = 1'b1;
                dec_legal    = 1'b1;
                case (funct)
                    6'h20: dec_alu = ALU_ADD;
                    6'h22: dec_alu = ALU_SUB;
                    6'h24: dec_alu = ALU_AND;
                    6'h25: dec_alu = ALU_OR;
                    6'h26: dec_alu = ALU_XOR;
                    6'h27: dec_alu = ALU_NOR;
                    6'h2A: dec_alu = ALU_SLT;
                    6'h00, 6'h02: begin
                        // Shift amount travels to the ALU in A[10:6]
                        dec_alu      = (funct == 6'h00) ? ALU_SLL : ALU_SRL;
                        dec_a        = {21'b0, shamt, 6'b0};
                        dec_reads_rs = 1'b0;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h1C: begin
`ifdef ID_EX_MUL_EN
                if (funct == 6'h02) begin
                    dec_legal    = 1'b1;
                    dec_alu      = ALU_MUL;
                    dec_rw       = 1'b1;
                    dec_reads_rt = 1'b1;
                end
`else
                dec_legal = 1'b0;
`endif
            end
            6'h08, 6'h0A, 6'h23, 6'h2B: begin
                dec_legal    = 1'b1;
                dec_alu      = (op == 6'h0A) ? ALU_SLT : ALU_ADD;
                dec_b        = imm_sext;
                dec_dest     = rt;
                dec_rw       = (op != 6'h2B);
                dec_mr       = (op == 6'h23);
                dec_mw       = (op == 6'h2B);
                dec_reads_rt = (op == 6'h2B);
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_legal = 1'b1;
                dec_alu   = (op == 6'h0C) ? ALU_AND : (op == 6'h0D) ? ALU_OR : ALU_XOR;
                dec_b     = imm_zext;
                dec_dest  = rt;
                dec_rw    = 1'b1;
            end
            6'h04, 6'h05: begin
                dec_legal    = 1'b1;
                dec_alu      = (op == 6'h04) ? ALU_BEQ : ALU_BNE;
                dec_br       = 1'b1;
                dec_dest     = 5'd0;
                dec_reads_rt = 1'b1;
            end
            6'h06, 6'h07: begin
                dec_legal = 1'b1;
                dec_alu   = (op == 6'h06) ? ALU_BLEZ : ALU_BGTZ;
                dec_br    = 1'b1;
                dec_b     = 32'd0;
                dec_dest  = 5'd0;
            end
            6'h01: begin
                dec_legal = (rt == 5'd0) || (rt == 5'd1);
                dec_alu   = (rt == 5'd0) ? ALU_BLTZ : ALU_BGEZ;
                dec_br    = 1'b1;
                dec_b     = 32'd0;
                dec_dest  = 5'd0;
            end
            default: dec_legal = 1'b0;
        endcase
        if (dec_dest == 5'd0) dec_rw = 1'b0;
    end

    logic        ex_valid_q, ex_valid_d;
    logic [4:0]  alu_control_q, alu_control_d;
    logic [31:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [31:0] ex_store_data_q, ex_store_data_d, ex_pc_plus4_q, ex_pc_plus4_d;
    logic [4:0]  ex_dest_reg_q, ex_dest_reg_d;
    logic        ex_reg_write_q, ex_reg_write_d, ex_mem_read_q, ex_mem_read_d;
    logic        ex_mem_write_q, ex_mem_write_d, ex_branch_q, ex_branch_d;
    logic        illegal_op_q, illegal_op_d;
    logic        hazard, load;

    // Only a legal, valid ID instruction can actually consume the loaded register
    always_comb begin
        hazard = ex_valid_q && ex_mem_read_q && (ex_dest_reg_q != 5'd0) &&
                 bus.InValid && dec_legal &&
                 ((dec_reads_rs && (rs == ex_dest_reg_q)) ||
                  (dec_reads_rt && (rt == ex_dest_reg_q)));
        load   = bus.InValid && dec_legal && !bus.Flush && !hazard;

        ex_valid_d      = load;
        alu_control_d   = load ? dec_alu       : ALU_NONE;
        ex_a_d          = load ? dec_a         : 32'd0;
        ex_b_d          = load ? dec_b         : 32'd0;
        ex_store_data_d = load ? bus.RtData    : 32'd0;
        ex_pc_plus4_d   = load ? bus.PCPlus4   : 32'd0;
        ex_dest_reg_d   = load ? dec_dest      : 5'd0;
        ex_reg_write_d  = load && dec_rw;
        ex_mem_read_d   = load && dec_mr;
        ex_mem_write_d  = load && dec_mw;
        ex_branch_d     = load && dec_br;
        illegal_op_d    = illegal_op_q || (bus.InValid && !dec_legal && !bus.Flush);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_valid_q      <= 1'b0;
            alu_control_q   <= ALU_NONE;
            ex_a_q          <= 32'd0;
            ex_b_q          <= 32'd0;
            ex_store_data_q <= 32'd0;
            ex_pc_plus4_q   <= 32'd0;
            ex_dest_reg_q   <= 5'd0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_branch_q     <= 1'b0;
            illegal_op_q    <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            alu_control_q   <= alu_control_d;
            ex_a_q          <= ex_a_d;
            ex_b_q          <= ex_b_d;
            ex_store_data_q <= ex_store_data_d;
            ex_pc_plus4_q   <= ex_pc_plus4_d;
            ex_dest_reg_q   <= ex_dest_reg_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_branch_q     <= ex_branch_d;
            illegal_op_q    <= illegal_op_d;
        end
    end

    assign bus.StallID     = hazard && !bus.Flush;
    assign bus.ExValid     = ex_valid_q;
    assign bus.ALUControl  = alu_control_q;
    assign bus.ExA         = ex_a_q;
    assign bus.ExB         = ex_b_q;
    assign bus.ExStoreData = ex_store_data_q;
    assign bus.ExPCPlus4   = ex_pc_plus4_q;
    assign bus.ExDestReg   = ex_dest_reg_q;
    assign bus.ExRegWrite  = ex_reg_write_q;
    assign bus.ExMemRead   = ex_mem_read_q;
    assign bus.ExMemWrite  = ex_mem_write_q;
    assign bus.ExBranch    = ex_branch_q;
    assign bus.IllegalOp   = illegal_op_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed bench for id_ex_stage (decode, load-use stall, flush, illegal ops)
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.Clk(clk), .Reset(reset), .bus(bus));

    localparam logic [31:0] I_ADD_3_1_2 = 32'h0022_1820;
    localparam logic [31:0] I_LW_4_8_1  = 32'h8C24_0008;
    localparam logic [31:0] I_ADD_5_4_2 = 32'h0082_2820;
    localparam logic [31:0] I_LW_5_0_4  = 32'h8C85_0000;
    localparam logic [31:0] I_ADD_6_5_0 = 32'h00A0_3020;
    localparam logic [31:0] I_SLL_2_3_4 = 32'h0003_1100;
    localparam logic [31:0] I_ADDI_FFFC = 32'h2026_FFFC;
    localparam logic [31:0] I_ANDI_8000 = 32'h3027_8000;
    localparam logic [31:0] I_BEQ       = 32'h1022_0010;
    localparam logic [31:0] I_BLTZ      = 32'h0420_0004;
    localparam logic [31:0] I_BAD       = 32'hFC00_0000;
    localparam logic [31:0] I_MUL       = 32'h7022_1802;

    task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input logic v, input logic f);
        bus.Instruction = ins;
        bus.RsData      = rs;
        bus.RtData      = rt;
        bus.PCPlus4     = 32'h0000_0400;
        bus.InValid     = v;
        bus.Flush       = f;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [181:0] all_out;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
            tick();
        end
        all_out = {bus.ExValid, bus.ALUControl, bus.ExA, bus.ExB, bus.ExStoreData, bus.ExPCPlus4,
                   bus.ExDestReg, bus.ExRegWrite, bus.ExMemRead, bus.ExMemWrite, bus.ExBranch,
                   bus.IllegalOp};
        checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %0h exp 0", all_out); end
        reset = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.StallID !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", bus.StallID); end
    endtask

    task automatic test_add;
        drive(I_ADD_3_1_2, 32'd5, 32'd7, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ALUControl !== 5'b00001) begin errors++; $display("FAIL add_alu got %b exp 00001", bus.ALUControl); end
        checks++; if (bus.ExA !== 32'd5 || bus.ExB !== 32'd7) begin errors++; $display("FAIL add_ops got %0d,%0d exp 5,7", bus.ExA, bus.ExB); end
        checks++; if (bus.ExDestReg !== 5'd3 || bus.ExRegWrite !== 1'b1 || bus.ExValid !== 1'b1) begin
            errors++; $display("FAIL add_ctl got dest=%0d rw=%0b v=%0b exp 3,1,1", bus.ExDestReg, bus.ExRegWrite, bus.ExValid); end
        checks++; if (bus.ExPCPlus4 !== 32'h400 || bus.ExStoreData !== 32'd7) begin
            errors++; $display("FAIL add_pass got pc=%0h sd=%0h exp 400,7", bus.ExPCPlus4, bus.ExStoreData); end
    endtask

    task automatic test_load_use;
        drive(I_LW_4_8_1, 32'd100, 32'd0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ExMemRead !== 1'b1 || bus.ExDestReg !== 5'd4 || bus.ExB !== 32'd8 || bus.ExA !== 32'd100) begin
            errors++; $display("FAIL lw_load got mr=%0b dest=%0d a=%0d b=%0d exp 1,4,100,8", bus.ExMemRead, bus.ExDestReg, bus.ExA, bus.ExB); end
        drive(I_ADD_5_4_2, 32'd1, 32'd2, 1'b1, 1'b0);
        #1;
        checks++; if (bus.StallID !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", bus.StallID); end
        tick();
        checks++; if (bus.ExValid !== 1'b0 || bus.ALUControl !== 5'd0 || bus.StallID !== 1'b0) begin
            errors++; $display("FAIL lu_bubble got v=%0b alu=%b stall=%0b exp 0,0,0", bus.ExValid, bus.ALUControl, bus.StallID); end
        tick();
        checks++; if (bus.ExValid !== 1'b1 || bus.ExDestReg !== 5'd5 || bus.ExRegWrite !== 1'b1 || bus.ALUControl !== 5'b00001) begin
            errors++; $display("FAIL lu_replay got v=%0b dest=%0d rw=%0b alu=%b exp 1,5,1,00001", bus.ExValid, bus.ExDestReg, bus.ExRegWrite, bus.ALUControl); end
    endtask

    task automatic test_shift_imm;
        drive(I_SLL_2_3_4, 32'hDEAD, 32'h1234, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ALUControl !== 5'b00100 || bus.ExA !== 32'h100 || bus.ExB !== 32'h1234 || bus.ExDestReg !== 5'd2) begin
            errors++; $display("FAIL sll got alu=%b a=%0h b=%0h dest=%0d exp 00100,100,1234,2", bus.ALUControl, bus.ExA, bus.ExB, bus.ExDestReg); end
        drive(I_ADDI_FFFC, 32'd9, 32'd0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ExB !== 32'hFFFF_FFFC || bus.ALUControl !== 5'b00001 || bus.ExDestReg !== 5'd6) begin
            errors++; $display("FAIL addi got b=%0h alu=%b dest=%0d exp fffffffc,00001,6", bus.ExB, bus.ALUControl, bus.ExDestReg); end
        drive(I_ANDI_8000, 32'd9, 32'd0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ExB !== 32'h0000_8000 || bus.ALUControl !== 5'b00110) begin
            errors++; $display("FAIL andi got b=%0h alu=%b exp 8000,00110", bus.ExB, bus.ALUControl); end
        drive(I_BEQ, 32'd1, 32'd1, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ALUControl !== 5'b01100 || bus.ExBranch !== 1'b1 || bus.ExRegWrite !== 1'b0) begin
            errors++; $display("FAIL beq got alu=%b br=%0b rw=%0b exp 01100,1,0", bus.ALUControl, bus.ExBranch, bus.ExRegWrite); end
        drive(I_BLTZ, 32'hFFFF_FFFF, 32'h55, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ALUControl !== 5'b10010 || bus.ExB !== 32'd0 || bus.ExBranch !== 1'b1) begin
            errors++; $display("FAIL bltz got alu=%b b=%0h br=%0b exp 10010,0,1", bus.ALUControl, bus.ExB, bus.ExBranch); end
        drive(32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ExValid !== 1'b1 || bus.ExRegWrite !== 1'b0 || bus.ALUControl !== 5'b00100 || bus.IllegalOp !== 1'b0) begin
            errors++; $display("FAIL nop got v=%0b rw=%0b alu=%b ill=%0b exp 1,0,00100,0", bus.ExValid, bus.ExRegWrite, bus.ALUControl, bus.IllegalOp); end
    endtask

    task automatic test_flush_hazard;
        drive(I_LW_4_8_1, 32'd100, 32'd0, 1'b1, 1'b0);
        tick();
        drive(I_ADD_5_4_2, 32'd1, 32'd2, 1'b1, 1'b1);
        #1;
        checks++; if (bus.StallID !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b exp 0", bus.StallID); end
        tick();
        checks++; if (bus.ExValid !== 1'b0 || bus.ExRegWrite !== 1'b0 || bus.ExA !== 32'd0) begin
            errors++; $display("FAIL flush_bubble got v=%0b rw=%0b a=%0h exp 0,0,0", bus.ExValid, bus.ExRegWrite, bus.ExA); end
    endtask

    task automatic test_back_to_back;
        drive(I_LW_4_8_1, 32'd100, 32'd0, 1'b1, 1'b0);
        tick();
        drive(I_LW_5_0_4, 32'd200, 32'd0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.StallID !== 1'b1) begin errors++; $display("FAIL b2b_stall1 got %0b exp 1", bus.StallID); end
        tick();
        checks++; if (bus.ExValid !== 1'b0 || bus.StallID !== 1'b0) begin
            errors++; $display("FAIL b2b_bubble1 got v=%0b stall=%0b exp 0,0", bus.ExValid, bus.StallID); end
        tick();
        checks++; if (bus.ExMemRead !== 1'b1 || bus.ExDestReg !== 5'd5) begin
            errors++; $display("FAIL b2b_lw2 got mr=%0b dest=%0d exp 1,5", bus.ExMemRead, bus.ExDestReg); end
        drive(I_ADD_6_5_0, 32'd3, 32'd0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.StallID !== 1'b1) begin errors++; $display("FAIL b2b_stall2 got %0b exp 1", bus.StallID); end
        tick();
        tick();
        checks++; if (bus.ExValid !== 1'b1 || bus.ExDestReg !== 5'd6 || bus.ExRegWrite !== 1'b1 || bus.StallID !== 1'b0) begin
            errors++; $display("FAIL b2b_add got v=%0b dest=%0d rw=%0b stall=%0b exp 1,6,1,0", bus.ExValid, bus.ExDestReg, bus.ExRegWrite, bus.StallID); end
    endtask

    task automatic test_reset_mid_stall;
        drive(I_LW_4_8_1, 32'd100, 32'd0, 1'b1, 1'b0);
        tick();
        drive(I_ADD_5_4_2, 32'd1, 32'd2, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.ExValid !== 1'b0 || bus.ExMemRead !== 1'b0 || bus.StallID !== 1'b0) begin
            errors++; $display("FAIL rst_stall got v=%0b mr=%0b stall=%0b exp 0,0,0", bus.ExValid, bus.ExMemRead, bus.StallID); end
        tick();
        checks++; if (bus.ExValid !== 1'b1 || bus.ExDestReg !== 5'd5) begin
            errors++; $display("FAIL rst_resume got v=%0b dest=%0d exp 1,5", bus.ExValid, bus.ExDestReg); end
    endtask

    task automatic test_illegal;
        drive(I_BAD, 32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        checks++; if (bus.IllegalOp !== 1'b0) begin errors++; $display("FAIL ill_invalid got %0b exp 0", bus.IllegalOp); end
        drive(I_BAD, 32'd1, 32'd2, 1'b1, 1'b0);
        tick();
        checks++; if (bus.IllegalOp !== 1'b1 || bus.ExValid !== 1'b0 || bus.ALUControl !== 5'd0) begin
            errors++; $display("FAIL ill_set got ill=%0b v=%0b alu=%b exp 1,0,0", bus.IllegalOp, bus.ExValid, bus.ALUControl); end
        drive(I_ADD_3_1_2, 32'd5, 32'd7, 1'b1, 1'b0);
        tick();
        checks++; if (bus.IllegalOp !== 1'b1 || bus.ExValid !== 1'b1) begin
            errors++; $display("FAIL ill_sticky got ill=%0b v=%0b exp 1,1", bus.IllegalOp, bus.ExValid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.IllegalOp !== 1'b0) begin errors++; $display("FAIL ill_clear got %0b exp 0", bus.IllegalOp); end
        drive(I_MUL, 32'd6, 32'd7, 1'b1, 1'b0);
        tick();
`ifdef ID_EX_MUL_EN
        checks++; if (bus.ALUControl !== 5'b00011 || bus.IllegalOp !== 1'b0 || bus.ExDestReg !== 5'd3) begin
            errors++; $display("FAIL mul got alu=%b ill=%0b dest=%0d exp 00011,0,3", bus.ALUControl, bus.IllegalOp, bus.ExDestReg); end
`else
        checks++; if (bus.ALUControl !== 5'd0 || bus.IllegalOp !== 1'b1 || bus.ExValid !== 1'b0) begin
            errors++; $display("FAIL mul got alu=%b ill=%0b v=%0b exp 0,1,0", bus.ALUControl, bus.IllegalOp, bus.ExValid); end
`endif
    endtask

    initial begin
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        test_reset();
        test_add();
        test_load_use();
        test_shift_imm();
        test_flush_hazard();
        test_back_to_back();
        test_reset_mid_stall();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
